// File: rtl/ssd1306_spi_if.sv
// CPU store-path bundle for the ssd1306_spi panel driver.
// master = CPU/bus side, slave = panel driver side.
interface ssd1306_spi_if;
   logic [31:0] data_in;
   logic        valid_comm;
   logic        valid_data;
   logic [31:0] data_address;
   logic [3:0]  Wmask;
   logic        busy;
   logic        done;

   modport master (
      output data_in, valid_comm, valid_data, data_address, Wmask,
      input  busy, done
   );

   modport slave (
      input  data_in, valid_comm, valid_data, data_address, Wmask,
      output busy, done
   );
endinterface

// File: rtl/ssd1306_spi.sv
// Write-only SPI master (mode 0, MSB first) for an SSD1306 128x64 OLED.
// Serialises the byte-masked CPU store onto sck/sda with the matching d_c
// level, and sequences the panel hardware reset after system reset.
// Optional feature macro: OLED_INIT_EN -- when defined, the block sends the
// panel power-on command sequence on its own before entering IDLE.
//
// state      | meaning
// -----------+---------------------------------------------------------
// RESET_LOW  | res held low for RES_CYCLES cycles
// RESET_WAIT | res high, RES_CYCLES settle time before first access
// IDLE       | busy=0, waiting for a command or data store
// SHIFT      | ss_ low, shifting the latched bytes out
// INIT       | (OLED_INIT_EN only) shifting the built-in init sequence
module ssd1306_spi #(
   parameter int CLK_DIV    = 2,
   parameter int RES_CYCLES = 120
) (
   input  logic         clk,
   input  logic         rst,
   ssd1306_spi_if.slave bus,
   output logic         ss_,
   output logic         sck,
   output logic         sda,
   output logic         res,
   output logic         d_c
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RES_W = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [RES_W-1:0] RES_LOAD = RES_W'(RES_CYCLES - 1);

`ifdef OLED_INIT_EN
   // display off, charge pump on, horizontal addressing, remap, display on
   localparam logic [63:0] INIT_SEQ = 64'hAE8D_1420_00A1_C8AF;

   typedef enum logic [2:0] {
      RESET_LOW, RESET_WAIT, IDLE, SHIFT, INIT
   } state_t;
`else
   typedef enum logic [2:0] {
      RESET_LOW, RESET_WAIT, IDLE, SHIFT
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [RES_W-1:0] res_cnt_q, res_cnt_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             sck_q, sck_d;
   logic [6:0]       bits_q, bits_d;
   logic [63:0]      shift_q, shift_d;
   logic             dc_q, dc_d;
   logic             done_q, done_d;

   logic             cmd_accept;
   logic             data_accept;
   logic             shifting;
   logic [31:0]      pack_bytes;
   logic [2:0]       pack_n;

   // The bus address is already decoded into the two strobes.
   logic unused_addr;
   assign unused_addr = ^bus.data_address;

   // Compact the enabled bytes, lowest byte lane first, into the top of a word.
   always_comb begin
      pack_bytes = '0;
      pack_n     = '0;
      for (int i = 3; i >= 0; i--) begin
         if (bus.Wmask[i]) begin
            pack_bytes = {bus.data_in[8*i +: 8], pack_bytes[31:8]};
            pack_n     = pack_n + 3'd1;
         end
      end
   end

   // valid_comm wins outright: a command store with byte 0 disabled is not
   // reinterpreted as a data store even if valid_data is also high.
   assign cmd_accept  = bus.valid_comm && bus.Wmask[0];
   assign data_accept = !bus.valid_comm && bus.valid_data && (bus.Wmask != 4'b0000);

`ifdef OLED_INIT_EN
   assign shifting = (state_q == SHIFT) || (state_q == INIT);
`else
   assign shifting = (state_q == SHIFT);
`endif

   // Next-state, counter and shift-register update.
   always_comb begin
      state_d   = state_q;
      res_cnt_d = res_cnt_q;
      div_cnt_d = div_cnt_q;
      sck_d     = sck_q;
      bits_d    = bits_q;
      shift_d   = shift_q;
      dc_d      = dc_q;
      done_d    = 1'b0;

      case (state_q)
         RESET_LOW: begin
            if (res_cnt_q == '0) begin
               state_d   = RESET_WAIT;
               res_cnt_d = RES_LOAD;
            end else begin
               res_cnt_d = res_cnt_q - 1'b1;
            end
         end
         RESET_WAIT: begin
            if (res_cnt_q == '0) begin
`ifdef OLED_INIT_EN
               state_d   = INIT;
               shift_d   = INIT_SEQ;
               bits_d    = 7'd64;
               dc_d      = 1'b0;
               div_cnt_d = DIV_LOAD;
               sck_d     = 1'b0;
`else
               state_d   = IDLE;
`endif
            end else begin
               res_cnt_d = res_cnt_q - 1'b1;
            end
         end
         IDLE: begin
            if (cmd_accept) begin
               state_d   = SHIFT;
               shift_d   = {bus.data_in[7:0], 56'd0};
               bits_d    = 7'd8;
               dc_d      = 1'b0;
               div_cnt_d = DIV_LOAD;
               sck_d     = 1'b0;
            end else if (data_accept) begin
               state_d   = SHIFT;
               shift_d   = {pack_bytes, 32'd0};
               bits_d    = {1'b0, pack_n, 3'b000};
               dc_d      = 1'b1;
               div_cnt_d = DIV_LOAD;
               sck_d     = 1'b0;
            end
         end
         default: ;
      endcase

      // Each bit: CLK_DIV cycles low, then CLK_DIV cycles high; sda advances
      // only at the high-to-low transition so it is stable across the rise.
      if (shifting) begin
         if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
         end else begin
            div_cnt_d = DIV_LOAD;
            if (!sck_q) begin
               sck_d = 1'b1;
            end else begin
               sck_d = 1'b0;
               if (bits_q == 7'd1) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  bits_d  = bits_q - 7'd1;
                  shift_d = {shift_q[62:0], 1'b0};
               end
            end
         end
      end
   end

   // State register; reset aborts any transfer and restarts the panel reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RESET_LOW;
         res_cnt_q <= RES_LOAD;
         div_cnt_q <= '0;
         sck_q     <= 1'b0;
         bits_q    <= '0;
         shift_q   <= '0;
         dc_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         res_cnt_q <= res_cnt_d;
         div_cnt_q <= div_cnt_d;
         sck_q     <= sck_d;
         bits_q    <= bits_d;
         shift_q   <= shift_d;
         dc_q      <= dc_d;
         done_q    <= done_d;
      end
   end

   assign ss_      = !shifting;
   assign sck      = sck_q;
   assign sda      = shifting & shift_q[63];
   assign res      = (state_q != RESET_LOW);
   assign d_c      = dc_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;

endmodule

// File: tb/tb_ssd1306_spi.sv
// Scoreboard bench for ssd1306_spi: stimulus predicts accepted bytes and
// busy windows from cycle arithmetic; a monitor decodes the SPI pins.
module tb_ssd1306_spi;
   localparam int CLK_DIV    = 2;
   localparam int RES_CYCLES = 4;
   localparam int BYTE_CYC   = 16 * CLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ss_, sck, sda, res, d_c;

   ssd1306_spi_if bus();

   ssd1306_spi #(.CLK_DIV(CLK_DIV), .RES_CYCLES(RES_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .ss_ (ss_),
      .sck (sck),
      .sda (sda),
      .res (res),
      .d_c (d_c)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // model state
   logic [8:0] exp_q[$];
   int         txn_q[$];
   int         free_at  = 0;
   int         p0       = 0;
   logic       in_reset = 1'b1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: decode sck rises into bytes, check busy/res windows and
   // per-transaction length against the model.
   initial begin
      int         bit_cnt, byte_cnt, ss_cnt, viol, n;
      logic [7:0] shreg;
      logic       prev_sck, prev_sda;
      logic [8:0] e;
      bit_cnt = 0; byte_cnt = 0; ss_cnt = 0; viol = 0;
      shreg = '0; prev_sck = 1'b0; prev_sda = 1'b0;
      forever begin
         @(negedge clk);
         if (in_reset) begin
            bit_cnt = 0; byte_cnt = 0; ss_cnt = 0; viol = 0;
            prev_sck = 1'b0; prev_sda = 1'b0;
         end else begin
            check("res_busy", {30'd0, res, bus.busy},
                  {30'd0, (cyc - p0 >= RES_CYCLES - 1), (cyc < free_at - 1)});
            if (!ss_) ss_cnt++;
            if (ss_ && sck) viol++;
            if (sck && prev_sck && (sda !== prev_sda)) viol++;
            if (sck && !prev_sck && !ss_) begin
               shreg = {shreg[6:0], sda};
               bit_cnt++;
               if (bit_cnt == 8) begin
                  bit_cnt = 0;
                  byte_cnt++;
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_byte: got dc=%0b byte=%02h expected none", d_c, shreg);
                  end else begin
                     e = exp_q.pop_front();
                     check("byte", {23'd0, d_c, shreg}, {23'd0, e});
                  end
               end
            end
            if (bus.done) begin
               if (txn_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
               end else begin
                  n = txn_q.pop_front();
                  check("txn_bytes", byte_cnt, n);
                  check("txn_ss_low", ss_cnt, BYTE_CYC * n);
                  check("txn_protocol", viol + bit_cnt, 0);
               end
               byte_cnt = 0; ss_cnt = 0; viol = 0; bit_cnt = 0;
            end
            prev_sck = sck;
            prev_sda = sda;
         end
      end
   end

   task automatic write(input logic comm, input logic dta, input logic [3:0] mask,
                        input logic [31:0] data);
      int c, n;
      @(negedge clk); #1;
      bus.valid_comm   = comm;
      bus.valid_data   = dta;
      bus.Wmask        = mask;
      bus.data_in      = data;
      bus.data_address = $urandom;
      c = cyc + 1;
      n = 0;
      if (!in_reset && c >= free_at) begin
         if (comm) begin
            if (mask[0]) begin
               exp_q.push_back({1'b0, data[7:0]});
               n = 1;
            end
         end else if (dta) begin
            for (int i = 0; i < 4; i++)
               if (mask[i]) begin
                  exp_q.push_back({1'b1, data[8*i +: 8]});
                  n++;
               end
         end
      end
      if (n > 0) begin
         txn_q.push_back(n);
         free_at = c + BYTE_CYC * n + 1;
      end
      @(negedge clk); #1;
      bus.valid_comm = 1'b0;
      bus.valid_data = 1'b0;
   endtask

   // Position so that the next write lands on the first cycle the model
   // expects the block to be free.
   task automatic wait_free();
      while (cyc + 2 < free_at) @(negedge clk);
   endtask

   task automatic do_reset(input int ncyc);
      @(negedge clk); #1;
      rst      = 1'b1;
      in_reset = 1'b1;
      exp_q.delete();
      txn_q.delete();
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         check("reset_outputs", {25'd0, ss_, sck, sda, d_c, res, bus.busy, bus.done},
               32'b1000010);
      end
      #1;
      rst      = 1'b0;
      p0       = cyc + 1;
      free_at  = p0 + 2 * RES_CYCLES;
      in_reset = 1'b0;
   endtask

   initial begin
      bus.valid_comm   = 1'b0;
      bus.valid_data   = 1'b0;
      bus.Wmask        = 4'h0;
      bus.data_in      = '0;
      bus.data_address = '0;

      do_reset(3);

      // command 0xAF, then data 0x78,0x34 with a dropped write mid-transfer
      wait_free();
      write(1'b1, 1'b0, 4'b0001, 32'h0000_00AF);
      wait_free();
      write(1'b0, 1'b1, 4'b0101, 32'h1234_5678);
      repeat (20) @(negedge clk);
      write(1'b0, 1'b1, 4'b1111, 32'h0000_00FF);

      // ignored masks, then both strobes (command wins)
      wait_free();
      write(1'b1, 1'b0, 4'b0010, 32'h0000_5500);
      write(1'b0, 1'b1, 4'b0000, 32'hDEAD_BEEF);
      write(1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D);

      // back-to-back: accepted in the done cycle
      wait_free();
      write(1'b0, 1'b1, 4'b1000, 32'hA500_0000);
      wait_free();
      write(1'b0, 1'b1, 4'b1111, 32'h0102_0304);

      // randomized stores, many landing while busy
      for (int t = 0; t < 40; t++) begin
         repeat ($urandom_range(0, 70)) @(negedge clk);
         write($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
               4'($urandom), $urandom);
      end

      // abort during bit 3 of a transfer, then power-up and one more command
      wait_free();
      write(1'b0, 1'b1, 4'b0011, 32'h0000_C3A5);
      repeat (13) @(negedge clk);
      do_reset(2);
      wait_free();
      write(1'b1, 1'b0, 4'b0001, 32'h0000_0081);

      for (int k = 0; k < 5000 && cyc < free_at + 3; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("exp_queue_drained", exp_q.size(), 0);
      check("txn_queue_drained", txn_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssd1306_spi.md
Name: ssd1306_spi

Overview:
- Write-only SPI master that drives an SSD1306 128x64 OLED panel from the SoC memory-mapped I/O bus.
- The CPU store path raises a command strobe or a data strobe with a 32-bit word and a byte mask. The block serialises the enabled bytes onto SCK/SDA with the correct D/C level.
- The block also generates the panel hardware reset (RES) after system reset.

Parameters:
- CLK_DIV, default 2: clk cycles per SCK half-period. Default gives 3 MHz SCK at 12 MHz.
- RES_CYCLES, default 120: clk cycles RES is held low after reset, and also the wait after RES rises.

Ports:
- clk, input, 1: system clock (12 MHz).
- rst, input, 1: reset. Synchronous, active-high.
- done, output, 1: one-cycle pulse when a transaction finishes.
- data_in, input, 32: store data from the CPU.
- valid_comm, input, 1: the store targets the command register (0x8000_00FC).
- valid_data, input, 32-bit word address decode, 1: the store targets the data register (0x8000_0100).
- data_address, input, 32: bus address. Reserved; it must not affect behaviour.
- Wmask, input, 4: byte write enables. Bit 0 enables data_in[7:0].
- busy, output, 1: the block cannot accept a write.
- ss_, output, 1: chip select, active low.
- sck, output, 1: SPI clock, mode 0 (idle low).
- sda, output, 1: MOSI, MSB first.
- res, output, 1: panel reset, active low.
- d_c, output, 1: 0 = command, 1 = data.

Behaviour:
- Reset values while rst=1: ss_=1, sck=0, sda=0, d_c=0, res=0, busy=1, done=0. Any transfer in progress is aborted immediately.
- Power-up sequence after rst deasserts:
  - res stays 0 for RES_CYCLES cycles, then res=1.
  - A further RES_CYCLES wait follows.
  - The block then enters IDLE with busy=0.
  - res stays 1 until the next rst.
- States: RESET_LOW, RESET_WAIT, IDLE, SHIFT, plus INIT when the optional feature is present.
- Accept condition (in IDLE, busy=0):
  - Command: valid_comm=1 and Wmask[0]=1. One byte, data_in[7:0], sent with d_c=0.
  - Data: valid_data=1 and Wmask!=0. The enabled bytes are sent in ascending byte order (byte0 first, masked bytes skipped), with d_c=1.
  - valid_comm has priority if both strobes are high.
  - Command with Wmask[0]=0, or Wmask=0: ignored.
- Writes that arrive while busy=1 are silently dropped. There is no queue.
- Accept cycle T: the bytes and d_c are latched; busy=1 from T+1.
- From T+1: ss_=0, d_c valid, sda=first bit.
- Each bit lasts 2*CLK_DIV cycles: sck=0 for CLK_DIV cycles with sda stable, then sck=1 for CLK_DIV cycles. sda changes only while sck=0.
- Bytes in one transaction are back-to-back; ss_ stays low between bytes.
- The cycle after the last bit's high phase: sck=0, ss_=1, busy=0, done=1 for exactly 1 cycle.
- A new write is accepted in that same cycle.
- Busy duration = 16*CLK_DIV*nbytes cycles (nbytes 1..4).
- d_c holds its last value while idle.

Optional Feature:
- OLED_INIT_EN defined: after RESET_WAIT, the block automatically sends this command sequence as one ss_-low transaction with d_c=0, busy held 1 throughout: 0xAE, 0x8D, 0x14, 0x20, 0x00, 0xA1, 0xC8, 0xAF.
- At the end of that sequence, done pulses once and the block goes to IDLE.
- OLED_INIT_EN undefined: the block goes straight to IDLE after RESET_WAIT, and the CPU performs initialisation.

Test Plan:
- Reset check, CLK_DIV=2, RES_CYCLES=4, OLED_INIT_EN undefined:
  - Hold rst 3 cycles → ss_=1, sck=0, res=0, busy=1.
  - After release, res=0 for 4 cycles, then res=1, and busy=0 after 4 more cycles.
- Command: valid_comm=1, Wmask=0001, data_in=0x000000AF → d_c=0, ss_ low for 32 cycles.
  - sda sampled on sck rising edges = 1,0,1,0,1,1,1,1.
  - done pulses 1 cycle, busy falls.
- Data: valid_data=1, Wmask=0101, data_in=0x12345678 → d_c=1, bytes 0x78 then 0x34 with no ss_ gap, busy for 64 cycles.
- Write while busy: issue data 0xFF mid-transfer → ignored, no extra SCK edges after done.
- Masks: command with Wmask=0010, and data with Wmask=0000 → no ss_ activity, busy stays 0.
- Abort: rst pulse during bit 3 of a transfer → outputs return to reset values next cycle and the power-up sequence restarts.
- OLED_INIT_EN defined: after reset, the 8 init bytes appear in order with d_c=0, followed by a single done pulse.
